// File: rtl/vcsr_elem_seq_pkg.sv
// Shared constants and types for the vector CSR file and element sequencer.
// vtype layout: [6] valid, [5:3] SEW encoding, [2:0] LMUL encoding.
package vcsr_elem_seq_pkg;

  localparam int VLEN_DEF    = 64;
  localparam int VL_W_DEF    = 7;
  localparam int VTYPE_W_DEF = 7;

  localparam int VTYPE_VALID_BIT = 6;
  localparam int SEW_MSB         = 5;
  localparam int SEW_LSB         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vcsr_elem_seq_vcsr_file.sv
// Architectural vector CSRs (vl, vtype, remaining AVL) loaded on a gated vsetvl commit.
module vcsr_elem_seq_vcsr_file
  import vcsr_elem_seq_pkg::*;
#(
  parameter int VLEN    = VLEN_DEF,
  parameter int VL_W    = VL_W_DEF,
  parameter int VTYPE_W = VTYPE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [VL_W-1:0]    new_vl_i,
  input  logic [VL_W-1:0]    new_avl_i,
  input  logic [VTYPE_W-1:0] new_vtype_i,
  output logic [VL_W-1:0]    vl_o,
  output logic [VTYPE_W-1:0] vtype_o,
  output logic [VL_W-1:0]    avl_rem_o,
  output logic               vill_o
);

  logic [VL_W-1:0]    vl_q, vl_d;
  logic [VL_W-1:0]    avl_q, avl_d;
  logic [VTYPE_W-1:0] vtype_q, vtype_d;

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latch).
    vl_d    = vl_q;
    avl_d   = avl_q;
    vtype_d = vtype_q;
    if (wr_en_i) begin
      // vl can never exceed VLEN, even if the upstream stage hands over a larger value.
      vl_d    = (new_vl_i > VL_W'(VLEN)) ? VL_W'(VLEN) : new_vl_i;
      avl_d   = new_avl_i;
      vtype_d = new_vtype_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vl_q    <= '0;
      avl_q   <= '0;
      vtype_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      vl_q    <= vl_d;
      avl_q   <= avl_d;
      vtype_q <= vtype_d;
    end
  end

  assign vl_o      = vl_q;
  assign vtype_o   = vtype_q;
  assign avl_rem_o = avl_q;
  assign vill_o    = ~vtype_q[VTYPE_VALID_BIT];

endmodule

// File: rtl/vcsr_elem_seq.sv
// Vector CSR holder plus element sequencer: streams indices 0..vl-1 per issued instruction.
module vcsr_elem_seq
  import vcsr_elem_seq_pkg::*;
#(
  parameter int VLEN    = VLEN_DEF,
  parameter int VL_W    = VL_W_DEF,
  parameter int VTYPE_W = VTYPE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vcsr_wen,
  input  logic [VL_W-1:0]    new_vl,
  input  logic [VL_W-1:0]    new_AVL,
  input  logic [VTYPE_W-1:0] new_vtype,
  output logic               csr_stall,
  output logic [VL_W-1:0]    vl,
  output logic [VTYPE_W-1:0] vtype,
  output logic [VL_W-1:0]    avl_rem,
  output logic               vill,
  input  logic               issue_valid,
  output logic               issue_ready,
  output logic               elem_valid,
  input  logic               elem_ready,
  output logic [VL_W-1:0]    elem_idx,
  output logic               elem_last,
  output logic [2:0]         elem_sew,
  output logic               done
);

  seq_state_e      state_q, state_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic            in_idle, csr_wr, issue_fire, elem_fire;

  // CSRs only change while idle, which keeps vl and SEW fixed for a whole instruction.
  assign in_idle   = (state_q == ST_IDLE);
  assign csr_wr    = vcsr_wen & in_idle;
  assign csr_stall = vcsr_wen & ~in_idle;

  vcsr_elem_seq_vcsr_file #(
    .VLEN   (VLEN),
    .VL_W   (VL_W),
    .VTYPE_W(VTYPE_W)
  ) u_vcsr_file (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (csr_wr),
    .new_vl_i   (new_vl),
    .new_avl_i  (new_AVL),
    .new_vtype_i(new_vtype),
    .vl_o       (vl),
    .vtype_o    (vtype),
    .avl_rem_o  (avl_rem),
    .vill_o     (vill)
  );

  // A same-cycle commit takes priority; the issue retries and sees the new vl.
  assign issue_ready = in_idle & ~vcsr_wen;
  assign issue_fire  = issue_valid & issue_ready;
  assign elem_valid  = (state_q == ST_RUN);
  assign elem_fire   = elem_valid & elem_ready;
  assign elem_last   = (vl != '0) && (idx_q == vl - VL_W'(1));
  assign elem_idx    = idx_q;
  assign elem_sew    = vtype[SEW_MSB:SEW_LSB];
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_fire) begin
          idx_d   = '0;
          state_d = (vill || vl == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (elem_fire) begin
          if (elem_last) state_d = ST_DONE;
          else           idx_d   = idx_q + VL_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_vcsr_elem_seq.sv
// Cycle-accurate directed bench for vcsr_elem_seq: a vector table plus a mid-RUN reset sequence.
module tb_vcsr_elem_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       vcsr_wen;
  logic [6:0] new_vl, new_AVL, new_vtype;
  logic       csr_stall;
  logic [6:0] vl, vtype, avl_rem;
  logic       vill;
  logic       issue_valid, issue_ready;
  logic       elem_valid, elem_ready;
  logic [6:0] elem_idx;
  logic       elem_last;
  logic [2:0] elem_sew;
  logic       done;

  always #5 clock = ~clock;

  vcsr_elem_seq dut (
    .clock      (clock),
    .reset      (reset),
    .vcsr_wen   (vcsr_wen),
    .new_vl     (new_vl),
    .new_AVL    (new_AVL),
    .new_vtype  (new_vtype),
    .csr_stall  (csr_stall),
    .vl         (vl),
    .vtype      (vtype),
    .avl_rem    (avl_rem),
    .vill       (vill),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_idx   (elem_idx),
    .elem_last  (elem_last),
    .elem_sew   (elem_sew),
    .done       (done)
  );

  typedef struct packed {
    logic       stall;
    logic [6:0] vl;
    logic [6:0] vtype;
    logic [6:0] avl;
    logic       vill;
    logic       ir;
    logic       ev;
    logic [6:0] idx;
    logic       last;
    logic [2:0] sew;
    logic       done;
  } out_t;

  typedef struct {
    logic       wen;
    logic [6:0] nvl, navl, nvt;
    logic       iv, er;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs driven, then outputs expected in that same cycle.
  task automatic add(input int wen, input int nvl, input int navl, input int nvt,
                     input int iv, input int er,
                     input int stall, input int evl, input int evt, input int eavl,
                     input int evill, input int eir, input int eev, input int eidx,
                     input int elast, input int esew, input int edone);
    vec_t v;
    v.wen       = (wen != 0);
    v.nvl       = 7'(nvl);
    v.navl      = 7'(navl);
    v.nvt       = 7'(nvt);
    v.iv        = (iv != 0);
    v.er        = (er != 0);
    v.exp.stall = (stall != 0);
    v.exp.vl    = 7'(evl);
    v.exp.vtype = 7'(evt);
    v.exp.avl   = 7'(eavl);
    v.exp.vill  = (evill != 0);
    v.exp.ir    = (eir != 0);
    v.exp.ev    = (eev != 0);
    v.exp.idx   = 7'(eidx);
    v.exp.last  = (elast != 0);
    v.exp.sew   = 3'(esew);
    v.exp.done  = (edone != 0);
    tbl.push_back(v);
  endtask

  function automatic out_t sample();
    out_t a;
    a.stall = csr_stall;  a.vl  = vl;         a.vtype = vtype;    a.avl  = avl_rem;
    a.vill  = vill;       a.ir  = issue_ready; a.ev   = elem_valid; a.idx = elem_idx;
    a.last  = elem_last;  a.sew = elem_sew;   a.done  = done;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_t a, e;
    logic saw_done;

    reset = 1'b1; vcsr_wen = 1'b0; new_vl = '0; new_AVL = '0; new_vtype = '0;
    issue_valid = 1'b0; elem_ready = 1'b0;
    #2;
    check("reset_hold", {vl, vtype, avl_rem, vill, issue_ready, elem_valid, elem_idx, done},
          {7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0});
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    //   wen vl avl vt   iv er | stall vl vt    avl vill ir ev idx last sew done
    add(0, 0, 0, 0,     0, 0,   0, 0, 0,     0,  1,  1, 0, 0, 0, 0, 0);  // after reset
    add(1, 8, 12, 'h40, 0, 0,   0, 0, 0,     0,  1,  0, 0, 0, 0, 0, 0);  // commit vl=8
    add(0, 0, 0, 0,     0, 0,   0, 8, 'h40,  12, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,     1, 1,   0, 8, 'h40,  12, 0,  1, 0, 0, 0, 0, 0);  // issue
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0,   0, 1,   0, 8, 'h40,  12, 0,  0, 1, k, (k == 7) ? 1 : 0, 0, 0);
    add(0, 0, 0, 0,     0, 0,   0, 8, 'h40,  12, 0,  0, 0, 0, 0, 0, 1);  // done pulse
    add(1, 4, 0, 'h48,  0, 0,   0, 8, 'h40,  12, 0,  0, 0, 0, 0, 0, 0);  // commit vl=4 SEW=1
    add(0, 0, 0, 0,     1, 0,   0, 4, 'h48,  0,  0,  1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0,     0, 1,   0, 4, 'h48,  0,  0,  0, 1, 0, 0, 1, 0);  // ready 1,0,0,1,1,1
    add(0, 0, 0, 0,     0, 0,   0, 4, 'h48,  0,  0,  0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0,     0, 0,   0, 4, 'h48,  0,  0,  0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0,     0, 1,   0, 4, 'h48,  0,  0,  0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0,     0, 1,   0, 4, 'h48,  0,  0,  0, 1, 2, 0, 1, 0);
    add(0, 0, 0, 0,     0, 1,   0, 4, 'h48,  0,  0,  0, 1, 3, 1, 1, 0);
    add(0, 0, 0, 0,     0, 0,   0, 4, 'h48,  0,  0,  0, 0, 0, 0, 1, 1);
    add(1, 5, 5, 'h00,  0, 0,   0, 4, 'h48,  0,  0,  0, 0, 0, 0, 1, 0);  // commit illegal vtype
    add(0, 0, 0, 0,     1, 1,   0, 5, 'h00,  5,  1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 1,   0, 5, 'h00,  5,  1,  0, 0, 0, 0, 0, 1);  // vill: straight to done
    add(1, 0, 0, 'h40,  0, 0,   0, 5, 'h00,  5,  1,  0, 0, 0, 0, 0, 0);  // commit vl=0
    add(0, 0, 0, 0,     1, 1,   0, 0, 'h40,  0,  0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 1,   0, 0, 'h40,  0,  0,  0, 0, 0, 0, 0, 1);  // vl=0: straight to done
    add(1, 8, 8, 'h40,  0, 0,   0, 0, 'h40,  0,  0,  0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 'h40,  1, 1,   0, 8, 'h40,  8,  0,  0, 0, 0, 0, 0, 0);  // commit+issue together
    add(0, 0, 0, 0,     1, 1,   0, 2, 'h40,  0,  0,  1, 0, 0, 0, 0, 0);  // issue retried
    add(0, 0, 0, 0,     0, 1,   0, 2, 'h40,  0,  0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 1,   0, 2, 'h40,  0,  0,  0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0,     0, 1,   0, 2, 'h40,  0,  0,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,     1, 0,   0, 2, 'h40,  0,  0,  1, 0, 0, 0, 0, 0);
    add(1, 9, 9, 'h50,  0, 0,   1, 2, 'h40,  0,  0,  0, 1, 0, 0, 0, 0);  // commit during RUN
    add(0, 0, 0, 0,     0, 1,   0, 2, 'h40,  0,  0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,     0, 1,   0, 2, 'h40,  0,  0,  0, 1, 1, 1, 0, 0);
    add(1, 9, 9, 'h50,  0, 0,   1, 2, 'h40,  0,  0,  0, 0, 0, 0, 0, 1);  // commit during DONE
    add(0, 0, 0, 0,     0, 0,   0, 2, 'h40,  0,  0,  1, 0, 0, 0, 0, 0);  // writes were dropped

    for (int i = 0; i < tbl.size(); i++) begin
      vcsr_wen    = tbl[i].wen;
      new_vl      = tbl[i].nvl;
      new_AVL     = tbl[i].navl;
      new_vtype   = tbl[i].nvt;
      issue_valid = tbl[i].iv;
      elem_ready  = tbl[i].er;
      #1;
      a = sample();
      e = tbl[i].exp;
      // Index and last flag only carry meaning while an element is valid.
      if (!e.ev) begin
        a.idx = '0; a.last = 1'b0;
        e.idx = '0; e.last = 1'b0;
      end
      check($sformatf("vec%0d", i), 64'(a), 64'(e));
      @(posedge clock);
      #1;
    end

    // Reset in the middle of a vl=8 instruction.
    vcsr_wen = 1'b1; new_vl = 7'd8; new_AVL = 7'd8; new_vtype = 7'h40;
    issue_valid = 1'b0; elem_ready = 1'b1;
    @(posedge clock); #1;
    vcsr_wen = 1'b0; issue_valid = 1'b1;
    @(posedge clock); #1;
    issue_valid = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    #1;
    check("run_idx3", {elem_valid, elem_idx}, {1'b1, 7'd3});
    #1 reset = 1'b1;
    #1;
    check("reset_async", {elem_valid, vl, vill, done, elem_idx}, {1'b0, 7'd0, 1'b1, 1'b0, 7'd0});
    @(posedge clock); #1 reset = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      #1 if (done) saw_done = 1'b1;
      @(posedge clock); #1;
    end
    check("no_done_after_reset", {saw_done, elem_valid}, {1'b0, 1'b0});
    check("idle_after_reset", {issue_ready, vl}, {1'b1, 7'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
